pla_act_pipe: RTL and testbench

Parametrised, pipelined piecewise-linear activation unit computing y = m[k]*x + c[k], where k is the segment selected by comparing x against NSEG-1 ascending breakpoints.
- Generalises the fixed 9-segment combinational softplus unit:
  - runtime-loadable coefficient/breakpoint table;
  - configurable width and segment count;
  - 3-stage valid/ready pipeline with backpressure.
- Sits between a neuron accumulator and the next layer's input buffer.

---
 rtl/pla_pkg.sv | 63 ++++++
 rtl/sm_mul_trunc.sv | 32 +++
 rtl/pla_act_pipe.sv | 132 +++++++++++++
 tb/tb_pla_act_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pla_pkg.sv
// pla_pkg: format constants, config encodings, the default 9-segment softplus
// table and sign-magnitude helpers shared by the activation unit.
package pla_pkg;

    localparam int PLA_WIDTH = 32;
    localparam int PLA_FRAC  = 27;
    localparam int PLA_NSEG  = 9;
    localparam int PLA_WMAX  = 64;  // widest word the compare/normalise helpers accept

    localparam logic [PLA_WIDTH-1:0] ONE        = 32'h0800_0000;
    localparam logic [PLA_WIDTH-1:0] SM_ZERO    = 32'h0000_0000;
    localparam logic [PLA_WIDTH-1:0] SM_MAX_MAG = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        CFG_SEL_M   = 2'd0,
        CFG_SEL_C   = 2'd1,
        CFG_SEL_BP  = 2'd2,
        CFG_SEL_RSV = 2'd3
    } cfg_sel_e;

    // Q5.27 sign-magnitude; breakpoints -3,-2,-1,-0.5,~0.385,1,2,4 (last entry is padding)
    localparam logic [31:0] DEF_M [PLA_NSEG] = '{
        32'h0040_0000, 32'h00A0_0000, 32'h0180_0000, 32'h0280_0000, 32'h0400_0000,
        32'h04C0_0000, 32'h0680_0000, 32'h0780_0000, 32'h0800_0000
    };
    localparam logic [31:0] DEF_C [PLA_NSEG] = '{
        32'h0100_0000, 32'h0240_0000, 32'h0400_0000, 32'h0500_0000, 32'h05B1_9EB2,
        32'h05B1_9EB2, 32'h0400_0000, 32'h0200_0000, 32'h0020_0000
    };
    localparam logic [31:0] DEF_BP [PLA_NSEG] = '{
        32'h9800_0000, 32'h9000_0000, 32'h8800_0000, 32'h8400_0000, 32'h0314_CCD4,
        32'h0800_0000, 32'h1000_0000, 32'h2000_0000, 32'h0000_0000
    };

    function automatic logic [PLA_WIDTH-1:0] def_entry(input cfg_sel_e sel, input int unsigned idx);
        logic [3:0] i;
        if (idx >= PLA_NSEG) return '0;
        i = idx[3:0];
        case (sel)
            CFG_SEL_M:  return DEF_M[i];
            CFG_SEL_C:  return DEF_C[i];
            CFG_SEL_BP: return DEF_BP[i];
            default:    return '0;
        endcase
    endfunction

    // a >= b on sign-magnitude values; -0 and +0 compare equal
    function automatic logic sm_ge(input logic a_s, input logic [PLA_WMAX-2:0] a_m,
                                   input logic b_s, input logic [PLA_WMAX-2:0] b_m);
        logic a_neg;
        logic b_neg;
        a_neg = a_s & (|a_m);
        b_neg = b_s & (|b_m);
        if (a_neg != b_neg) return b_neg;
        if (a_neg) return (a_m <= b_m);
        return (a_m >= b_m);
    endfunction

    function automatic logic sm_norm(input logic s, input logic [PLA_WMAX-2:0] mag);
        return s & (|mag);
    endfunction

endpackage

// File: rtl/sm_mul_trunc.sv
// sm_mul_trunc: sign-magnitude multiply, magnitude truncated by FRAC bits, with
// overflow flag. Saturates instead of wrapping when PLA_SAT_EN is defined.
module sm_mul_trunc
    import pla_pkg::*;
#(
    parameter int WIDTH = PLA_WIDTH,
    parameter int FRAC  = PLA_FRAC
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic             ovf
);
    localparam int MW = WIDTH - 1;

    logic [2*MW-1:0] full;
    logic [2*MW-1:0] shifted;
    logic [MW-1:0]   mag;

    always_comb begin
        full    = (2*MW)'(a[MW-1:0]) * (2*MW)'(b[MW-1:0]);
        shifted = full >> FRAC;
        ovf     = |shifted[2*MW-1:MW];
`ifdef PLA_SAT_EN
        mag     = ovf ? '1 : shifted[MW-1:0];
`else
        mag     = shifted[MW-1:0];
`endif
        p       = {a[MW] ^ b[MW], mag};
    end

endmodule

// File: rtl/pla_act_pipe.sv
// pla_act_pipe: 3-stage valid/ready piecewise-linear activation y = m[k]*x + c[k]
// with a runtime-loadable table. Define PLA_SAT_EN to saturate instead of wrap.
module pla_act_pipe
    import pla_pkg::*;
#(
    parameter int WIDTH = PLA_WIDTH,
    parameter int FRAC  = PLA_FRAC,
    parameter int NSEG  = PLA_NSEG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_ovf,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [$clog2(NSEG)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]        cfg_data
);
    localparam int MW = WIDTH - 1;
    localparam int AW = $clog2(NSEG);
    localparam int PM = PLA_WMAX - 1;

    logic [WIDTH-1:0] m_tab  [NSEG];
    logic [WIDTH-1:0] c_tab  [NSEG];
    logic [WIDTH-1:0] bp_tab [NSEG];  // entry NSEG-1 never written nor read

    logic             stall;
    logic [AW-1:0]    seg;
    logic             s1_valid, s2_valid;
    logic [WIDTH-1:0] s1_x, s1_m, s1_c;
    logic [WIDTH-1:0] s2_p, s2_c;
    logic             s2_povf;
    logic [WIDTH-1:0] mul_p;
    logic             mul_ovf;
    logic [MW:0]      sum;
    logic [MW-1:0]    add_mag;
    logic             add_sign, add_ovf;

    // Softplus defaults only make sense in the 32-bit Q5.27 format they were built for
    function automatic logic [WIDTH-1:0] tab_default(input cfg_sel_e sel, input int unsigned idx);
        if (NSEG == PLA_NSEG && WIDTH == PLA_WIDTH) return WIDTH'(def_entry(sel, idx));
        return '0;
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSEG; i++) begin
                m_tab[i]  <= tab_default(CFG_SEL_M, i);
                c_tab[i]  <= tab_default(CFG_SEL_C, i);
                bp_tab[i] <= tab_default(CFG_SEL_BP, i);
            end
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_M:  if (int'(cfg_addr) < NSEG)     m_tab[cfg_addr]  <= cfg_data;
                CFG_SEL_C:  if (int'(cfg_addr) < NSEG)     c_tab[cfg_addr]  <= cfg_data;
                CFG_SEL_BP: if (int'(cfg_addr) < NSEG - 1) bp_tab[cfg_addr] <= cfg_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        seg = '0;
        for (int unsigned i = 0; i < NSEG - 1; i++) begin
            if (sm_ge(in_data[MW], PM'(in_data[MW-1:0]), bp_tab[i][MW], PM'(bp_tab[i][MW-1:0])))
                seg = seg + AW'(1);
        end
    end

    sm_mul_trunc #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .a   (s1_x),
        .b   (s1_m),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    always_comb begin
        sum     = {1'b0, s2_p[MW-1:0]} + {1'b0, s2_c[MW-1:0]};
        add_ovf = 1'b0;
        if (s2_p[MW] == s2_c[MW]) begin
            add_sign = s2_p[MW];
            add_mag  = sum[MW-1:0];
            add_ovf  = sum[MW];
`ifdef PLA_SAT_EN
            if (sum[MW]) add_mag = '1;
`endif
        end else if (s2_p[MW-1:0] >= s2_c[MW-1:0]) begin
            add_sign = s2_p[MW];
            add_mag  = s2_p[MW-1:0] - s2_c[MW-1:0];
        end else begin
            add_sign = s2_c[MW];
            add_mag  = s2_c[MW-1:0] - s2_p[MW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_m      <= '0;
            s1_c      <= '0;
            s2_valid  <= 1'b0;
            s2_p      <= '0;
            s2_povf   <= 1'b0;
            s2_c      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_x      <= in_data;
            s1_m      <= m_tab[seg];
            s1_c      <= c_tab[seg];
            s2_valid  <= s1_valid;
            s2_p      <= mul_p;
            s2_povf   <= mul_ovf;
            s2_c      <= s1_c;
            out_valid <= s2_valid;
            out_data  <= {sm_norm(add_sign, PM'(add_mag)), add_mag};
            out_ovf   <= s2_povf | add_ovf;
        end
    end

endmodule

// File: tb/tb_pla_act_pipe.sv
// tb_pla_act_pipe: directed vectors against the default softplus table; expected
// results are queued on accept and compared by an independent output monitor.
module tb_pla_act_pipe;
    import pla_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;

    int total = 0;
    int bad   = 0;
    int acc   = 0;
    logic [32:0] exp_q  [$];
    string       name_q [$];

    localparam logic [31:0] BP4 = 32'h0314_CCD4;
`ifdef PLA_SAT_EN
    localparam logic [31:0] ADD_OVF_Y = SM_MAX_MAG;
    localparam logic [31:0] MUL_OVF_Y = SM_MAX_MAG;
`else
    localparam logic [31:0] ADD_OVF_Y = 32'h1FFF_FFFF;
    localparam logic [31:0] MUL_OVF_Y = 32'h7FFF_FFF1;
`endif

    always #5 clk = ~clk;

    pla_act_pipe #(.WIDTH(32), .FRAC(27), .NSEG(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present x until accepted; queue {ovf, y} when track is set
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ovf,
                        input string name, input bit track = 1'b1);
        in_valid = 1'b1;
        in_data  = x;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: got in_ready=0 want 1 within 50 cycles", name);
        end else begin
            acc++;
            if (track) begin
                exp_q.push_back({ovf, y});
                name_q.push_back(name);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input cfg_sel_e sel, input logic [3:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() > 0; n++) @(posedge clk);
        #1;
        check("drain_pending", 33'(exp_q.size()), 33'd0);
    endtask

    initial begin : monitor
        logic [32:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h want none", {out_ovf, out_data});
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, {out_ovf, out_data}, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 33'(out_valid), 33'd0);
        check("rst_out_data",  33'(out_data),  33'd0);
        check("rst_out_ovf",   33'(out_ovf),   33'd0);
        check("rst_in_ready",  33'(in_ready),  33'd1);

        send(32'h0000_0000, 32'h05B1_9EB2, 1'b0, "zero");
        send(32'h8000_0000, 32'h05B1_9EB2, 1'b0, "neg_zero");
        send(BP4,           32'h0785_F84F, 1'b0, "bp_edge_hi");
        send(32'h0314_CCD3, 32'h073C_051B, 1'b0, "bp_edge_lo");
        send(32'h9F00_0000, 32'h0008_0000, 1'b0, "below_bp0");
        send(32'h0800_0000, 32'h0A80_0000, 1'b0, "bp_one");
        send(32'h8C00_0000, 32'h01C0_0000, 1'b0, "neg_1p5");
        drain();

        send(32'h0000_0000, 32'h05B1_9EB2, 1'b0, "latency");
        check("lat_c1", 33'(out_valid), 33'd0);
        @(posedge clk); #1;
        check("lat_c2", 33'(out_valid), 33'd0);
        @(posedge clk); #1;
        check("lat_c3", 33'(out_valid), 33'd1);
        drain();

        acc = 0;
        out_ready = 1'b0;
        fork
            begin
                send(32'h0000_0000, 32'h05B1_9EB2, 1'b0, "bp_a");
                send(BP4,           32'h0785_F84F, 1'b0, "bp_b");
                send(32'h0314_CCD3, 32'h073C_051B, 1'b0, "bp_c");
                send(32'h9F00_0000, 32'h0008_0000, 1'b0, "bp_d");
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                check("stall_accepted", 33'(acc), 33'd3);
                check("stall_in_ready", 33'(in_ready), 33'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        cfg_write(CFG_SEL_M, 4'd8, ONE);
        cfg_write(CFG_SEL_C, 4'd8, SM_ZERO);
        send(32'h2000_0000, 32'h2000_0000, 1'b0, "unit_slope");
        cfg_write(CFG_SEL_C, 4'd8, 32'hA000_0000);
        send(32'h2000_0000, SM_ZERO, 1'b0, "zero_is_pos");
        cfg_write(CFG_SEL_C, 4'd8, 32'h7FFF_FFFF);
        send(32'h2000_0000, ADD_OVF_Y, 1'b1, "add_ovf");
        cfg_write(CFG_SEL_M, 4'd8, 32'h7FFF_FFFF);
        cfg_write(CFG_SEL_C, 4'd8, SM_ZERO);
        send(32'h7800_0000, MUL_OVF_Y, 1'b1, "mul_ovf");
        cfg_write(CFG_SEL_RSV, 4'd0, 32'h7FFF_FFFF);
        send(32'h9F00_0000, 32'h0008_0000, 1'b0, "rsv_ignored");
        drain();

        cfg_we = 1'b1; cfg_sel = CFG_SEL_C; cfg_addr = 4'd5; cfg_data = 32'h0100_0000;
        send(BP4, 32'h0785_F84F, 1'b0, "race_old");
        cfg_we = 1'b0;
        send(BP4, 32'h02D4_599D, 1'b0, "race_new");
        drain();

        out_ready = 1'b0;
        send(32'h0000_0000, 32'h0, 1'b0, "flush_a", 1'b0);
        send(32'h0000_0000, 32'h0, 1'b0, "flush_b", 1'b0);
        send(32'h0000_0000, 32'h0, 1'b0, "flush_c", 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("flush_no_output", 33'(seen), 33'd0);
        send(BP4,           32'h0785_F84F, 1'b0, "restored_c5");
        send(32'h2000_0000, 32'h2020_0000, 1'b0, "restored_m8");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
